// File: rtl/codec_cfg_sequencer.sv
// WM8731 configuration sequencer: walks the fixed 11-entry register table through the
// I2C write engine, with power-up wait, inter-write gap, NACK/timeout retry and status.
module codec_cfg_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         PWRUP_CYCLES   = 50000,
    parameter int         GAP_CYCLES     = 500,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        i2c_req,
    output logic [6:0]  i2c_dev_addr,
    output logic [15:0] i2c_word,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [3:0]  cfg_index
);

    localparam int CNT_MAX_A = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int RTY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RETRY_LIMIT  = RTY_W'(MAX_RETRY);
    localparam logic [3:0]       LAST_INDEX   = 4'd10;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       index, index_nxt;
    logic [RTY_W-1:0] retry, retry_nxt;
    logic             last_ok, last_ok_nxt;

    // Register table entries are {reg[6:0], data[8:0]}.
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h1E00;
            4'd1:    w = 16'h0C00;
            4'd2:    w = 16'h0E02;
            4'd3:    w = 16'h1000;
            4'd4:    w = 16'h0017;
            4'd5:    w = 16'h0217;
            4'd6:    w = 16'h0479;
            4'd7:    w = 16'h0679;
            4'd8:    w = 16'h0812;
            4'd9:    w = 16'h0A00;
            4'd10:   w = 16'h1201;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_PWRUP;
            cnt     <= '0;
            index   <= '0;
            retry   <= '0;
            last_ok <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            index   <= index_nxt;
            retry   <= retry_nxt;
            last_ok <= last_ok_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        index_nxt   = index;
        retry_nxt   = retry;
        last_ok_nxt = last_ok;
        case (state)
            S_PWRUP: begin
                if (cnt == PWRUP_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_ISSUE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A done in the timeout cycle takes priority over the timeout.
                if (i2c_done && !i2c_nack) begin
                    retry_nxt   = '0;
                    last_ok_nxt = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = S_GAP;
                end else if (i2c_done || (cnt == TIMEOUT_LAST)) begin
                    cnt_nxt = '0;
                    if (retry < RETRY_LIMIT) begin
                        retry_nxt   = retry + 1'b1;
                        last_ok_nxt = 1'b0;
                        state_nxt   = S_GAP;
                    end else begin
                        state_nxt = S_ERROR;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if (!last_ok) begin
                        state_nxt = S_ISSUE;
                    end else if (index == LAST_INDEX) begin
                        state_nxt = S_DONE;
                    end else begin
                        index_nxt = index + 4'd1;
                        state_nxt = S_ISSUE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    index_nxt   = '0;
                    retry_nxt   = '0;
                    last_ok_nxt = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = S_ISSUE;
                end
            end
            default: state_nxt = S_PWRUP;
        endcase
    end

    always_comb begin
        i2c_req   = (state == S_ISSUE);
        cfg_done  = (state == S_DONE);
        cfg_error = (state == S_ERROR);
        cfg_busy  = !((state == S_DONE) || (state == S_ERROR));
    end

    assign i2c_dev_addr = DEV_ADDR;
    assign i2c_word     = table_word(index);
    assign cfg_index    = index;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer with a behavioural I2C engine responder
// and small timing parameters.
module tb_codec_cfg_sequencer;

    localparam int P = 50;   // power-up cycles
    localparam int G = 8;    // gap cycles
    localparam int T = 300;  // timeout cycles
    localparam int R = 3;    // max retries
    localparam int D = 20;   // engine ack delay after i2c_req

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        i2c_req;
    logic [6:0]  i2c_dev_addr;
    logic [15:0] i2c_word;
    logic        cfg_busy, cfg_done, cfg_error;
    logic [3:0]  cfg_index;

    codec_cfg_sequencer #(
        .DEV_ADDR(7'h1A), .PWRUP_CYCLES(P), .GAP_CYCLES(G),
        .TIMEOUT_CYCLES(T), .MAX_RETRY(R)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .i2c_req(i2c_req), .i2c_dev_addr(i2c_dev_addr), .i2c_word(i2c_word),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
        .cfg_index(cfg_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_tbl [0:10] = '{16'h1E00, 16'h0C00, 16'h0E02, 16'h1000, 16'h0017,
                                    16'h0217, 16'h0479, 16'h0679, 16'h0812, 16'h0A00,
                                    16'h1201};

    logic [15:0] log_word [0:63];
    logic [3:0]  log_idx  [0:63];
    int          log_cyc  [0:63];
    int          nlog = 0;
    int          epoch = 0;
    int          nack_left [0:10] = '{default: 0};
    bit          silent    [0:10] = '{default: 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (cfg_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_complete"}, (n < budget), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   i2c_req, 0);
        check({tag, "_busy"},  cfg_busy, 1);
        check({tag, "_done"},  cfg_done, 0);
        check({tag, "_error"}, cfg_error, 0);
        check({tag, "_index"}, cfg_index, 0);
        check({tag, "_word"},  i2c_word, 16'h1E00);
        check({tag, "_addr"},  i2c_dev_addr, 7'h1A);
    endtask

    // I2C engine model: logs each request, then acks/nacks D cycles later unless silent.
    initial begin : responder
        int          ep;
        logic [15:0] w;
        logic [3:0]  ix;
        forever begin
            @(negedge clk);
            if (i2c_req === 1'b1) begin
                w  = i2c_word;
                ix = cfg_index;
                ep = epoch;
                if (nlog < 64) begin
                    log_word[nlog] = w;
                    log_idx[nlog]  = ix;
                    log_cyc[nlog]  = cyc;
                end
                nlog++;
                @(negedge clk);
                check("req_single_cycle", i2c_req, 0);
                if (!silent[ix]) begin
                    repeat (D - 1) @(negedge clk);
                    if (ep == epoch) begin
                        check("word_stable_in_wait", i2c_word, w);
                        check("index_stable_in_wait", cfg_index, ix);
                    end
                    i2c_nack = (nack_left[ix] > 0);
                    if (nack_left[ix] > 0) nack_left[ix]--;
                    i2c_done = 1'b1;
                    @(negedge clk);
                    i2c_done = 1'b0;
                    i2c_nack = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c0;
        int s;
        int n;
        int ex;

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");

        // Clean run; release cycle counts as cycle 1, so first req lands P cycles after it
        nlog  = 0;
        reset = 1'b0;
        c0    = cyc;
        wait_idle(3000, "run1");
        check("run1_nreq", nlog, 11);
        check("run1_first_req_lat", log_cyc[0] - c0, P);
        check("run1_ack_to_req", log_cyc[1] - log_cyc[0], D + G + 1);
        for (int i = 0; i < 11; i++) check("run1_word", log_word[i], exp_tbl[i]);
        check("run1_done", cfg_done, 1);
        check("run1_busy", cfg_busy, 0);
        check("run1_error", cfg_error, 0);
        check("run1_index", cfg_index, 10);

        // Start from DONE, single NACK on entry 2, stray start mid-sequence
        nack_left[2] = 1;
        nlog = 0;
        s = cyc;
        pulse_start();
        check("start_req_lat", cyc - s, 1);
        check("start_req", i2c_req, 1);
        repeat (100) @(negedge clk);
        check("run2_busy_mid", cfg_busy, 1);
        pulse_start();
        wait_idle(3000, "run2");
        check("run2_nreq", nlog, 12);
        for (int i = 0; i < 12; i++) begin
            ex = (i <= 2) ? i : i - 1;
            check("run2_index", log_idx[i], ex);
            check("run2_word", log_word[i], exp_tbl[ex]);
        end
        check("run2_done", cfg_done, 1);
        check("run2_error", cfg_error, 0);

        // Entry 5 NACKs forever -> 4 attempts then ERROR
        nack_left[5] = 100;
        nlog = 0;
        pulse_start();
        wait_idle(3000, "run3");
        check("run3_nreq", nlog, 9);
        for (int i = 0; i < 9; i++) check("run3_word", log_word[i], exp_tbl[(i < 5) ? i : 5]);
        check("run3_error", cfg_error, 1);
        check("run3_done", cfg_done, 0);
        check("run3_busy", cfg_busy, 0);
        check("run3_index", cfg_index, 5);
        repeat (200) @(negedge clk);
        check("run3_no_more_req", nlog, 9);
        nack_left[5] = 0;

        // Engine silent on entry 0 -> timeouts, start honoured from ERROR
        silent[0] = 1'b1;
        nlog = 0;
        pulse_start();
        wait_idle(5000, "run4");
        check("run4_nreq", nlog, 4);
        for (int i = 0; i < 4; i++) check("run4_word", log_word[i], 16'h1E00);
        for (int i = 0; i < 3; i++) check("run4_period", log_cyc[i+1] - log_cyc[i], T + G + 1);
        check("run4_error", cfg_error, 1);
        check("run4_index", cfg_index, 0);
        silent[0] = 1'b0;

        // Reset during WAIT of entry 7
        nlog = 0;
        pulse_start();
        n = 0;
        while (nlog < 8 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("run5_reach_entry7", (n < 3000), 1);
        repeat (5) @(negedge clk);
        check("run5_index_pre_reset", cfg_index, 7);
        reset = 1'b1;
        epoch++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst2");
        nlog  = 0;
        reset = 1'b0;
        c0    = cyc;
        wait_idle(3000, "run5");
        check("run5_nreq", nlog, 11);
        check("run5_first_req_lat", log_cyc[0] - c0, P);
        for (int i = 0; i < 11; i++) check("run5_word", log_word[i], exp_tbl[i]);
        check("run5_done", cfg_done, 1);
        check("run5_error", cfg_error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/codec_cfg_sequencer.md
Name: codec_cfg_sequencer

Overview:
- Sequences the I2C write engine to program the WM8731 audio codec on the DE10-Standard after power-up, or on request.
- Walks a fixed 11-entry register table. For each entry it issues one write, waits for completion, retries on NACK or timeout, and waits a gap between writes.
- Reports busy, done and error status to the audio top level. The I2S path is enabled only after cfg_done.

Parameters:
DEV_ADDR, 7'h1A, codec 7-bit I2C address driven on i2c_dev_addr.
PWRUP_CYCLES, 50000, clk cycles to wait after reset before the first write (1 ms at 50 MHz).
GAP_CYCLES, 500, idle clk cycles between consecutive writes.
TIMEOUT_CYCLES, 100000, max clk cycles to wait for i2c_done after i2c_req.
MAX_RETRY, 3, retries per entry after the first attempt fails.

Ports:
clk  in  1  system clock, 50 MHz.
reset  in  1  synchronous, active-high reset.
start  in  1  single-cycle pulse; re-runs the full table from entry 0. Honoured only in DONE or ERROR.
i2c_req  out  1  single-cycle pulse; launches one write on the I2C engine.
i2c_dev_addr  out  7  always DEV_ADDR.
i2c_word  out  16  current table word {reg[6:0], data[8:0]}; stable from i2c_req until i2c_done.
i2c_done  in  1  single-cycle pulse from the engine; transaction finished.
i2c_nack  in  1  valid in the i2c_done cycle; 1 = codec did not acknowledge.
cfg_busy  out  1  high in every state except DONE and ERROR.
cfg_done  out  1  high in DONE; level signal.
cfg_error  out  1  high in ERROR; level signal.
cfg_index  out  4  table index currently being written, 0..10.

Behaviour:
- Register table (index: word):
  - 0: 0x1E00 (reset)
  - 1: 0x0C00 (power on)
  - 2: 0x0E02 (I2S, 16-bit, slave)
  - 3: 0x1000 (48 kHz normal)
  - 4: 0x0017
  - 5: 0x0217
  - 6: 0x0479
  - 7: 0x0679
  - 8: 0x0812
  - 9: 0x0A00
  - 10: 0x1201 (active)
- Reset, synchronous:
  - state=PWRUP; counter=0; index=0; retry=0.
  - i2c_req=0; cfg_busy=1; cfg_done=0; cfg_error=0; cfg_index=0.
  - i2c_word=table[0].
  - Reset asserted mid-transaction abandons the sequence. An i2c_done arriving after reset release while in PWRUP is ignored.
- States:
  - PWRUP: count to PWRUP_CYCLES-1, then go to ISSUE.
  - ISSUE: assert i2c_req for exactly one cycle; clear the timeout counter; go to WAIT.
  - WAIT:
    - i2c_done with nack=0: retry=0; go to GAP.
    - i2c_done with nack=1, or timeout counter reaching TIMEOUT_CYCLES-1 without done:
      - retry<MAX_RETRY: retry+1; go to GAP with the same index.
      - otherwise: go to ERROR.
  - GAP: count GAP_CYCLES cycles. Then:
    - last write succeeded and index==10: go to DONE.
    - last write succeeded, index<10: index+1; go to ISSUE.
    - retry pending: go to ISSUE with the same index.
  - DONE / ERROR: hold. start=1 → index=0; retry=0; go to ISSUE with no PWRUP wait.
- Simultaneous events:
  - i2c_done in the same cycle the timeout expires: done wins (timeout ignored).
  - start outside DONE/ERROR is ignored.
  - i2c_done outside WAIT is ignored.
- Latency:
  - reset release to first i2c_req = PWRUP_CYCLES+1 cycles.
  - i2c_done (ack) to next i2c_req = GAP_CYCLES+2 cycles.
- Output stability: i2c_word and cfg_index change only on the index increment in GAP or on reset/start. Never while in WAIT.
- Counters are wide enough for the largest of PWRUP/GAP/TIMEOUT; no wrap inside a state.
- Successful run: exactly 11 i2c_req pulses plus one per retry.

Test Plan:
- Reset, engine model acks every write after 200 cycles → 11 i2c_req pulses; words 0x1E00..0x1201 in table order; cfg_done=1, cfg_busy=0, cfg_error=0; first req at cycle PWRUP_CYCLES+1.
- NACK on entry 2 once, then ack → entry 2 (0x0E02) issued twice; total 12 req; cfg_done=1; cfg_index never skips or goes back.
- Entry 5 NACKs on all attempts → exactly MAX_RETRY+1=4 req with 0x0217; cfg_error=1, cfg_busy=0, cfg_index=5; no further req.
- Engine never returns done on entry 0 → req repeats every TIMEOUT_CYCLES+GAP_CYCLES+1 cycles, 4 total; then cfg_error=1.
- In DONE, pulse start → sequence reruns from 0x1E00 immediately (req one cycle after start, no PWRUP wait); start pulsed mid-sequence has no effect.
- Assert reset during WAIT of entry 7 and hold 3 cycles → outputs at reset values, i2c_word=0x1E00; after release, PWRUP wait completes and a fresh 11-write sequence runs.
